muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit with its own sequencing FSM. Sits beside the
//  execute-stage ALU. Execute hands it an M-extension op through a valid/ready request
//  port and holds its stage (ready=0) until the result is taken from the response port.
//  One operation in flight at a time. Flush kills the operation in flight.
// PARAMETERS
//  XLEN           32  operand/result width
//  BITS_PER_CYCLE 1   iteration radix (1, 2 or 4; must divide XLEN); N_ITER = XLEN/BITS_PER_CYCLE
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst         in   1     synchronous reset, active-high
//  req_valid   in   1     op/a/b valid this cycle
//  req_ready   out  1     unit can accept a request
//  op          in   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                         100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a           in   XLEN  rs1 operand (dividend / multiplicand)
//  b           in   XLEN  rs2 operand (divisor / multiplier)
//  flush       in   1     abort the current operation; response discarded
//  resp_valid  out  1     resp_value holds the final result
//  resp_ready  in   1     consumer takes the result
//  resp_value  out  XLEN  result
//  busy        out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, resp_valid=0, resp_value=0, counter=0, busy=0.
//    req_ready is 0 while rst=1.
//  - FSM states: IDLE, CALC, DONE.
//  - req_ready = (state==IDLE) && !flush && !rst, driven combinationally.
//    Accept means req_valid && req_ready at an edge. On accept, latch op, the sign flags
//    and the magnitudes |a| and |b|. Sign handling:
//      MUL/MULH/DIV/REM: a and b signed. MULHSU: a signed, b unsigned. U ops: unsigned.
//  - IDLE -> DONE on accept when a special case applies; result computed directly,
//    1-cycle latency:
//      DIV/DIVU with b==0: quotient = all ones; REM/REMU with b==0: rem = a.
//      DIV with a==0x80000000 and b==-1: quotient = 0x80000000; REM in that case: rem = 0.
//  - IDLE -> CALC on any other accept. counter=0.
//  - CALC: each cycle retires BITS_PER_CYCLE bits. Multiply is unsigned shift-add into a
//    2*XLEN product. Divide is restoring shift-subtract giving XLEN-bit quotient and
//    remainder. counter increments each cycle. When counter==N_ITER-1: apply sign fixup,
//    register resp_value, go to DONE.
//    Default latency: accept edge E -> resp_valid high in the cycle after edge E+N_ITER
//    (33 cycles for XLEN=32, BITS_PER_CYCLE=1).
//  - Sign fixup:
//      product negated if the operand signs differ.
//      MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//      quotient negated if sign(a)^sign(b); remainder takes the sign of a.
//  - DONE: resp_valid=1; resp_value stable until handshake. On resp_valid && resp_ready,
//    go to IDLE and drop resp_valid. No request is accepted in DONE; next accept is
//    earliest one cycle later.
//  - flush (any state): next state IDLE, resp_valid=0, counter=0, no response emitted.
//    Flush beats a same-cycle accept (req_ready=0) and a same-cycle response handshake.
//  - rst mid-operation behaves like flush and also clears resp_value.
//  - Inputs a/b/op may change after accept without affecting the result.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD -> resp_value 0xFFFFFFEB; resp_valid first high exactly
//     33 cycles after the accept edge.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//     MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF;
//     DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
//     REM same operands -> 0. All with resp_valid in the cycle after the accept edge.
//  5. Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_value stable,
//     req_ready=0 throughout; resp_ready=1 -> IDLE next cycle, req_ready=1.
//  6. Flush in CALC cycle 10 -> IDLE next cycle, resp_valid never asserted.
//     Flush together with req_valid in IDLE -> request not accepted.
//     rst in DONE -> resp_valid=0 and resp_value=0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with a valid/ready request port and a held response.
// Magnitudes are iterated unsigned (shift-add / restoring divide), signs are fixed up on the last step.
module muldiv_sequencer #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_value,
  output logic            busy
);

  localparam int N_ITER = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] counter;
  logic             sign_a, sign_b;
  // Multiply: operand = |a|, acc_lo = remaining multiplier bits, acc_hi = partial product.
  // Divide:   operand = |b|, acc_lo = dividend shifting into quotient, acc_hi = remainder.
  logic [XLEN-1:0]  operand, acc_hi, acc_lo;

  op_t             op_in;
  logic            accept, special, sign_a_in, sign_b_in, div_in;
  logic [XLEN-1:0] special_value, abs_a, abs_b;

  assign req_ready = (state == IDLE) && !flush && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    op_in         = op_t'(op);
    div_in        = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    sign_a_in     = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
    sign_b_in     = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
    special       = 1'b0;
    special_value = '0;
    if (div_in && b == '0) begin
      special       = 1'b1;
      special_value = (op_in inside {OP_REM, OP_REMU}) ? a : '1;
    end else if ((op_in inside {OP_DIV, OP_REM}) &&
                 a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      special       = 1'b1;
      special_value = (op_in == OP_DIV) ? a : '0;
    end
  end

  assign abs_a = sign_a_in ? -a : a;
  assign abs_b = sign_b_in ? -b : b;

  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN:0]   rem_trial, sum;

  always_comb begin
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    rem_trial = '0;
    sum       = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
        rem_trial = {step_hi, step_lo[XLEN-1]};
        step_lo   = {step_lo[XLEN-2:0], 1'b0};
        if (rem_trial >= {1'b0, operand}) begin
          rem_trial  = rem_trial - {1'b0, operand};
          step_lo[0] = 1'b1;
        end
        step_hi = rem_trial[XLEN-1:0];
      end else begin
        sum                = {1'b0, step_hi} + (step_lo[0] ? {1'b0, operand} : '0);
        {step_hi, step_lo} = {sum, step_lo[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]   result;

  always_comb begin
    product     = {step_hi, step_lo};
    product_fix = (sign_a ^ sign_b) ? -product : product;
    case (op_q)
      OP_MUL:                       result = product_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = product_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = (sign_a ^ sign_b) ? -step_lo : step_lo;
      default:                      result = sign_a ? -step_hi : step_hi;
    endcase
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      sign_a  <= sign_a_in;
      sign_b  <= sign_b_in;
      acc_hi  <= '0;
      acc_lo  <= div_in ? abs_a : abs_b;
      operand <= div_in ? abs_b : abs_a;
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_value <= '0;
      counter    <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      counter    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            counter <= '0;
            if (special) begin
              resp_value <= special_value;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          counter <= counter + 1'b1;
          if (counter == CNT_W'(N_ITER - 1)) begin
            resp_value <= result;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a transaction-level arithmetic model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_muldiv_sequencer;

  localparam int N_ITER = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_value;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_value (resp_value),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Result of an RV32M op from plain 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic        [63:0] up;
    logic signed [31:0] dx, dy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'b0, y};
    up = {32'b0, x} * {32'b0, y};
    dx = x;
    dy = y;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return dx / dy;
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return dx % dy;
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return (o[2] && y == 32'd0) ||
           ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Transaction model: one op in flight, result visible 1 cycle (special) or N_ITER+1 cycles after accept.
  bit          started = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_value = '0;
  logic [31:0] m_result = '0;
  int          cyc = 0;
  int          m_due = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
      m_value   = '0;
      started   = 1'b1;
    end else if (flush) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
    end else if (m_valid) begin
      if (resp_ready) m_valid = 1'b0;
    end else if (m_pending) begin
      if (cyc == m_due) begin
        m_valid   = 1'b1;
        m_value   = m_result;
        m_pending = 1'b0;
      end
    end else if (req_valid) begin
      if (is_special(op, a, b)) begin
        m_valid = 1'b1;
        m_value = model_result(op, a, b);
      end else begin
        m_pending = 1'b1;
        m_result  = model_result(op, a, b);
        m_due     = cyc + N_ITER;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("req_ready", 32'(req_ready), 32'(!m_pending && !m_valid && !rst && !flush));
      check("busy", 32'(busy), 32'(m_pending || m_valid));
      check("resp_valid", 32'(resp_valid), 32'(m_valid));
      check("resp_value", resp_value, m_value);
    end
  end

  // Called away from a clock edge with the unit idle; returns at posedge+2 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    op = ~o;
    a = $urandom;
    b = $urandom;
  endtask

  // Returns on the negedge where resp_valid is first seen; latency counted in negedges after accept.
  task automatic wait_resp(input string name, input int exp_lat, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check(name, resp_value, exp);
  endtask

  task automatic take();
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #2 resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y, e;
    int          lat;
  } vec_t;

  vec_t vecs[14] = '{
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
    '{3'd5, 32'd100,       32'd7,         32'd14,        33},
    '{3'd7, 32'd100,       32'd7,         32'd2,         33},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
    '{3'd6, 32'd5,         32'd0,         32'd5,         1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1},
    '{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 33},
    '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
    '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int hi_count;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_value", resp_value, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(req_ready), 32'd1);
    #1;

    // MUL with 33-cycle latency, then a 5-cycle stall while a new request waits.
    check("mul model", model_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_resp("mul", 33, 32'hFFFF_FFEB);
    #1;
    op = 3'd0; a = 32'd1; b = 32'd1; req_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("hold resp_valid", 32'(resp_valid), 32'd1);
    check("hold resp_value", resp_value, 32'hFFFF_FFEB);
    check("hold req_ready", 32'(req_ready), 32'd0);
    #1 req_valid = 1'b0;
    take();
    @(negedge clk);
    check("after take resp_valid", 32'(resp_valid), 32'd0);
    check("after take req_ready", 32'(req_ready), 32'd1);
    #1;

    foreach (vecs[i]) begin
      check($sformatf("vec%0d model", i), model_result(vecs[i].o, vecs[i].x, vecs[i].y), vecs[i].e);
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      wait_resp($sformatf("vec%0d", i), vecs[i].lat, vecs[i].e);
      take();
    end

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = (i % 4 == 3) ? 32'd0 : $urandom;
      issue(ro, rx, ry);
      wait_resp($sformatf("rand%0d op%0d", i, ro), is_special(ro, rx, ry) ? 1 : N_ITER + 1,
                model_result(ro, rx, ry));
      take();
    end

    // Flush during CALC: no response may ever appear.
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0;
    @(negedge clk);
    check("flush calc busy", 32'(busy), 32'd0);
    check("flush calc req_ready", 32'(req_ready), 32'd1);
    hi_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) hi_count++;
    end
    check("flush calc no resp", 32'(hi_count), 32'd0);
    #1;

    // Flush together with a request in IDLE: not accepted.
    @(posedge clk);
    #2 flush = 1'b1; req_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    check("flush req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush req busy", 32'(busy), 32'd0);
    #1;

    // Flush beats a same-cycle response handshake; resp_value holds.
    issue(3'd5, 32'd5, 32'd0);
    wait_resp("flush done pre", 1, 32'hFFFF_FFFF);
    #1 flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check("flush done resp_valid", 32'(resp_valid), 32'd0);
    check("flush done resp_value", resp_value, 32'hFFFF_FFFF);
    #1;

    // Reset in DONE clears the result.
    issue(3'd5, 32'd100, 32'd7);
    wait_resp("rst done pre", 33, 32'd14);
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst done resp_valid", 32'(resp_valid), 32'd0);
    check("rst done resp_value", resp_value, 32'd0);
    #1;

    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("mul after rst", 33, 32'd1);
    take();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
